// File: rtl/ddr3_int_ex_rdata_checker.sv
// ---------------------------------------------------------------------------
// ddr3_int_ex_rdata_checker
//
// Purpose: checks a run of read-data beats against a per-lane 8-bit
// pseudo-random pattern. Each byte lane has its own generator, which is
// seeded with (SEED + lane) and stepped once per valid beat. A start pulse
// launches a run of BEATS valid beats. When the run ends, done/pass and the
// error status hold until the next start.
//
// Parameters:
//   SEED   8-bit expected-data seed (lane n uses SEED[7:0] + n)
//   LANES  byte lanes per beat (1..16)
//   BEATS  valid beats per run (1..65535)
//
// Ports:
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   start        one-cycle pulse that begins a run (ignored while busy)
//   rdata_valid  rdata carries a beat this cycle (ignored unless busy)
//   rdata        read data, lane n at [8n+7:8n]
//   busy         a run is in progress
//   done         the run has completed and the status is final
//   pass         done with zero mismatching beats
//   err_count    mismatching beats, saturating at 16'hFFFF
//   lane_err     sticky per-lane mismatch flags
//
// Optional feature (macro DDR3_INT_EX_CHK_FIRST_FAIL_EN):
//   first_fail_beat  zero-based index of the first mismatching beat
//   first_fail_data  rdata of that beat
// ---------------------------------------------------------------------------
module ddr3_int_ex_rdata_checker #(
  parameter int SEED  = 32,
  parameter int LANES = 4,
  parameter int BEATS = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               rdata_valid,
  input  logic [8*LANES-1:0] rdata,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [15:0]        err_count,
  output logic [LANES-1:0]   lane_err
`ifdef DDR3_INT_EX_CHK_FIRST_FAIL_EN
  ,
  output logic [15:0]        first_fail_beat,
  output logic [8*LANES-1:0] first_fail_data
`endif
);

  typedef enum logic [1:0] {IDLE, CHECK, DONE} state_e;

  localparam logic [15:0] LAST_BEAT = 16'(BEATS - 1);

  function automatic logic [8*LANES-1:0] seed_vec();
    logic [8*LANES-1:0] v;
    logic [7:0]         s;
    s = 8'(SEED);
    for (int n = 0; n < LANES; n++) begin
      v[8*n +: 8] = s + 8'(n);
    end
    return v;
  endfunction

  localparam logic [8*LANES-1:0] SEED_VEC = seed_vec();

  // Galois-style step of x^8 + x^4 + x^3 + x^2 + 1; never reaches zero.
  function automatic logic [7:0] gen_step(input logic [7:0] d);
    return {d[6], d[5], d[4], d[3] ^ d[7], d[2] ^ d[7], d[1] ^ d[7], d[0], d[7]};
  endfunction

  state_e             state_q, state_d;
  logic [8*LANES-1:0] gen_q, gen_d;
  logic [15:0]        beat_cnt_q, beat_cnt_d;
  logic [15:0]        err_count_q, err_count_d;
  logic [LANES-1:0]   lane_err_q, lane_err_d;
  logic [LANES-1:0]   lane_mis;

`ifdef DDR3_INT_EX_CHK_FIRST_FAIL_EN
  logic               ff_seen_q, ff_seen_d;
  logic [15:0]        ff_beat_q, ff_beat_d;
  logic [8*LANES-1:0] ff_data_q, ff_data_d;
`endif

  // NOTE: every variable assigned here gets a default first, so no path
  // through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    gen_d       = gen_q;
    beat_cnt_d  = beat_cnt_q;
    err_count_d = err_count_q;
    lane_err_d  = lane_err_q;
    lane_mis    = '0;
`ifdef DDR3_INT_EX_CHK_FIRST_FAIL_EN
    ff_seen_d   = ff_seen_q;
    ff_beat_d   = ff_beat_q;
    ff_data_d   = ff_data_q;
`endif

    for (int n = 0; n < LANES; n++) begin
      lane_mis[n] = (rdata[8*n +: 8] != gen_q[8*n +: 8]);
    end

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d     = CHECK;
          gen_d       = SEED_VEC;
          beat_cnt_d  = '0;
          err_count_d = '0;
          lane_err_d  = '0;
`ifdef DDR3_INT_EX_CHK_FIRST_FAIL_EN
          ff_seen_d   = 1'b0;
          ff_beat_d   = '0;
          ff_data_d   = '0;
`endif
        end
      end
      CHECK: begin
        if (rdata_valid) begin
          for (int n = 0; n < LANES; n++) begin
            gen_d[8*n +: 8] = gen_step(gen_q[8*n +: 8]);
          end
          beat_cnt_d = beat_cnt_q + 16'd1;
          lane_err_d = lane_err_q | lane_mis;
          if ((|lane_mis) && (err_count_q != 16'hFFFF)) begin
            err_count_d = err_count_q + 16'd1;
          end
`ifdef DDR3_INT_EX_CHK_FIRST_FAIL_EN
          if ((|lane_mis) && !ff_seen_q) begin
            ff_seen_d = 1'b1;
            ff_beat_d = beat_cnt_q;
            ff_data_d = rdata;
          end
`endif
          if (beat_cnt_q == LAST_BEAT) begin
            state_d = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      gen_q       <= SEED_VEC;
      beat_cnt_q  <= '0;
      err_count_q <= '0;
      lane_err_q  <= '0;
`ifdef DDR3_INT_EX_CHK_FIRST_FAIL_EN
      ff_seen_q   <= 1'b0;
      ff_beat_q   <= '0;
      ff_data_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      gen_q       <= gen_d;
      beat_cnt_q  <= beat_cnt_d;
      err_count_q <= err_count_d;
      lane_err_q  <= lane_err_d;
`ifdef DDR3_INT_EX_CHK_FIRST_FAIL_EN
      ff_seen_q   <= ff_seen_d;
      ff_beat_q   <= ff_beat_d;
      ff_data_q   <= ff_data_d;
`endif
    end
  end

  assign busy      = (state_q == CHECK);
  assign done      = (state_q == DONE);
  assign pass      = done && (err_count_q == 16'd0);
  assign err_count = err_count_q;
  assign lane_err  = lane_err_q;
`ifdef DDR3_INT_EX_CHK_FIRST_FAIL_EN
  assign first_fail_beat = ff_beat_q;
  assign first_fail_data = ff_data_q;
`endif

endmodule

// File: tb/tb_ddr3_int_ex_rdata_checker.sv
module tb_ddr3_int_ex_rdata_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n = 1'b0;

  // Instance A: LANES=1, SEED=32, BEATS=4
  logic        start_a = 1'b0, valid_a = 1'b0;
  logic [7:0]  rdata_a = '0;
  logic        busy_a, done_a, pass_a;
  logic [15:0] err_a;
  logic [0:0]  lerr_a;

  // Instance B: LANES=4, SEED=32, BEATS=65535
  logic        start_b = 1'b0, valid_b = 1'b0;
  logic [31:0] rdata_b = '0;
  logic        busy_b, done_b, pass_b;
  logic [15:0] err_b;
  logic [3:0]  lerr_b;

`ifdef DDR3_INT_EX_CHK_FIRST_FAIL_EN
  logic [15:0] ffb_a, ffb_b;
  logic [7:0]  ffd_a;
  logic [31:0] ffd_b;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  ddr3_int_ex_rdata_checker #(.SEED(32), .LANES(1), .BEATS(4)) dut_a (
    .clk(clk), .reset_n(reset_n), .start(start_a), .rdata_valid(valid_a),
    .rdata(rdata_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .err_count(err_a), .lane_err(lerr_a)
`ifdef DDR3_INT_EX_CHK_FIRST_FAIL_EN
    , .first_fail_beat(ffb_a), .first_fail_data(ffd_a)
`endif
  );

  ddr3_int_ex_rdata_checker #(.SEED(32), .LANES(4), .BEATS(65535)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start_b), .rdata_valid(valid_b),
    .rdata(rdata_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .err_count(err_b), .lane_err(lerr_b)
`ifdef DDR3_INT_EX_CHK_FIRST_FAIL_EN
    , .first_fail_beat(ffb_b), .first_fail_data(ffd_b)
`endif
  );

  // Results captured by run_a for the calling test to compare.
  logic [15:0] err_seen [4];
  logic        done_before_last, done_after_last;

  // Runs one 4-beat check on instance A. Inputs change on the falling edge;
  // outputs are sampled on the falling edge after each capturing rising edge.
  // mid_start marks the beat index during which start is also pulsed (-1 none).
  task automatic run_a(input logic [7:0] b0, input logic [7:0] b1,
                       input logic [7:0] b2, input logic [7:0] b3,
                       input int gap, input int mid_start);
    logic [7:0] beats [4];
    beats[0] = b0; beats[1] = b1; beats[2] = b2; beats[3] = b3;
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    for (int k = 0; k < 4; k++) begin
      valid_a = 1'b1;
      rdata_a = beats[k];
      start_a = (k == mid_start);
      if (k == 3) done_before_last = done_a;
      @(negedge clk);
      start_a = 1'b0;
      valid_a = 1'b0;
      rdata_a = 8'hA5;
      err_seen[k] = err_a;
      if (k == 3) done_after_last = done_a;
      else for (int g = 0; g < gap; g++) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    #1;
    tests_run++;
    if ({busy_a, done_a, pass_a, err_a, lerr_a} !== 20'h0) begin
      tests_failed++;
      $display("FAIL reset_a: got %h expected 0", {busy_a, done_a, pass_a, err_a, lerr_a});
    end
    tests_run++;
    if ({busy_b, done_b, pass_b, err_b, lerr_b} !== 23'h0) begin
      tests_failed++;
      $display("FAIL reset_b: got %h expected 0", {busy_b, done_b, pass_b, err_b, lerr_b});
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    // rdata_valid in IDLE must be ignored
    valid_a = 1'b1;
    rdata_a = 8'h00;
    repeat (3) @(negedge clk);
    valid_a = 1'b0;
    tests_run++;
    if ({busy_a, done_a, err_a, lerr_a} !== 19'h0) begin
      tests_failed++;
      $display("FAIL idle_valid_ignored: got %h expected 0", {busy_a, done_a, err_a, lerr_a});
    end
  endtask

  task automatic test_clean();
    run_a(8'h20, 8'h40, 8'h80, 8'h1D, 0, -1);
    tests_run++;
    if ({done_a, pass_a, busy_a, err_a, lerr_a} !== {1'b1, 1'b1, 1'b0, 16'd0, 1'b0}) begin
      tests_failed++;
      $display("FAIL clean_run: done/pass/busy/err/lane got %b/%b/%b/%h/%b expected 1/1/0/0000/0",
               done_a, pass_a, busy_a, err_a, lerr_a);
    end
    tests_run++;
    if (done_before_last !== 1'b0 || done_after_last !== 1'b1) begin
      tests_failed++;
      $display("FAIL clean_done_timing: got %b%b expected 01", done_before_last, done_after_last);
    end
  endtask

  task automatic test_error();
    run_a(8'h20, 8'h40, 8'h81, 8'h1D, 0, -1);
    tests_run++;
    if ({done_a, pass_a, err_a, lerr_a} !== {1'b1, 1'b0, 16'd1, 1'b1}) begin
      tests_failed++;
      $display("FAIL error_run: done/pass/err/lane got %b/%b/%h/%b expected 1/0/0001/1",
               done_a, pass_a, err_a, lerr_a);
    end
    tests_run++;
    if ({err_seen[0], err_seen[1], err_seen[2], err_seen[3]} !== {16'd0, 16'd0, 16'd1, 16'd1}) begin
      tests_failed++;
      $display("FAIL error_timing: got %h %h %h %h expected 0 0 1 1",
               err_seen[0], err_seen[1], err_seen[2], err_seen[3]);
    end
`ifdef DDR3_INT_EX_CHK_FIRST_FAIL_EN
    tests_run++;
    if (ffb_a !== 16'd2 || ffd_a !== 8'h81) begin
      tests_failed++;
      $display("FAIL first_fail: beat/data got %0d/%h expected 2/81", ffb_a, ffd_a);
    end
`endif
    // DONE holds its status while idle cycles pass
    repeat (5) @(negedge clk);
    tests_run++;
    if ({done_a, pass_a, err_a, lerr_a} !== {1'b1, 1'b0, 16'd1, 1'b1}) begin
      tests_failed++;
      $display("FAIL done_hold: got %b/%b/%h/%b expected 1/0/0001/1", done_a, pass_a, err_a, lerr_a);
    end
    // start in DONE returns to CHECK with status cleared
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    tests_run++;
    if ({busy_a, done_a, err_a, lerr_a} !== {1'b1, 1'b0, 16'd0, 1'b0}) begin
      tests_failed++;
      $display("FAIL restart_from_done: busy/done/err/lane got %b/%b/%h/%b expected 1/0/0000/0",
               busy_a, done_a, err_a, lerr_a);
    end
`ifdef DDR3_INT_EX_CHK_FIRST_FAIL_EN
    tests_run++;
    if (ffb_a !== 16'd0 || ffd_a !== 8'h00) begin
      tests_failed++;
      $display("FAIL first_fail_clear: got %0d/%h expected 0/00", ffb_a, ffd_a);
    end
`endif
    // Finish this run with clean beats so the block returns to DONE.
    valid_a = 1'b1;
    foreach (err_seen[k]) begin
      rdata_a = (k == 0) ? 8'h20 : (k == 1) ? 8'h40 : (k == 2) ? 8'h80 : 8'h1D;
      @(negedge clk);
    end
    valid_a = 1'b0;
    tests_run++;
    if (pass_a !== 1'b1) begin
      tests_failed++;
      $display("FAIL rerun_pass: got %b expected 1", pass_a);
    end
  endtask

  task automatic test_gaps();
    run_a(8'h20, 8'h40, 8'h80, 8'h1D, 3, -1);
    tests_run++;
    if ({done_a, pass_a, err_a} !== {1'b1, 1'b1, 16'd0}) begin
      tests_failed++;
      $display("FAIL gap_run: done/pass/err got %b/%b/%h expected 1/1/0000", done_a, pass_a, err_a);
    end
    tests_run++;
    if (done_before_last !== 1'b0 || done_after_last !== 1'b1) begin
      tests_failed++;
      $display("FAIL gap_done_timing: got %b%b expected 01", done_before_last, done_after_last);
    end
  endtask

  task automatic test_mid_start();
    run_a(8'h20, 8'h40, 8'h80, 8'h1D, 1, 2);
    tests_run++;
    if ({done_a, pass_a, err_a, lerr_a} !== {1'b1, 1'b1, 16'd0, 1'b0}) begin
      tests_failed++;
      $display("FAIL mid_start_ignored: done/pass/err/lane got %b/%b/%h/%b expected 1/1/0000/0",
               done_a, pass_a, err_a, lerr_a);
    end
    // rdata_valid in DONE is ignored as well
    valid_a = 1'b1;
    rdata_a = 8'h00;
    repeat (3) @(negedge clk);
    valid_a = 1'b0;
    tests_run++;
    if ({done_a, pass_a, err_a} !== {1'b1, 1'b1, 16'd0}) begin
      tests_failed++;
      $display("FAIL done_valid_ignored: got %b/%b/%h expected 1/1/0000", done_a, pass_a, err_a);
    end
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    valid_a = 1'b1;
    rdata_a = 8'h00;
    repeat (2) @(negedge clk);
    valid_a = 1'b0;
    tests_run++;
    if ({busy_a, err_a, lerr_a} !== {1'b1, 16'd2, 1'b1}) begin
      tests_failed++;
      $display("FAIL pre_reset_status: busy/err/lane got %b/%h/%b expected 1/0002/1", busy_a, err_a, lerr_a);
    end
    #2 reset_n = 1'b0;
    #1;
    tests_run++;
    if ({busy_a, done_a, pass_a, err_a, lerr_a} !== 20'h0) begin
      tests_failed++;
      $display("FAIL in_reset_outputs: got %h expected 0", {busy_a, done_a, pass_a, err_a, lerr_a});
    end
`ifdef DDR3_INT_EX_CHK_FIRST_FAIL_EN
    tests_run++;
    if (ffb_a !== 16'd0 || ffd_a !== 8'h00) begin
      tests_failed++;
      $display("FAIL in_reset_first_fail: got %0d/%h expected 0/00", ffb_a, ffd_a);
    end
`endif
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({busy_a, done_a, err_a, lerr_a} !== 19'h0) begin
      tests_failed++;
      $display("FAIL post_reset_residue: got %h expected 0", {busy_a, done_a, err_a, lerr_a});
    end
    run_a(8'h20, 8'h40, 8'h80, 8'h1D, 0, -1);
    tests_run++;
    if ({done_a, pass_a, err_a} !== {1'b1, 1'b1, 16'd0}) begin
      tests_failed++;
      $display("FAIL post_reset_run: done/pass/err got %b/%b/%h expected 1/1/0000", done_a, pass_a, err_a);
    end
  endtask

  task automatic test_saturate();
    @(negedge clk);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    valid_b = 1'b1;
    rdata_b = 32'h0;
    for (int k = 0; k < 65535; k++) @(negedge clk);
    valid_b = 1'b0;
    tests_run++;
    if ({done_b, pass_b, busy_b} !== 3'b100) begin
      tests_failed++;
      $display("FAIL sat_done: done/pass/busy got %b/%b/%b expected 1/0/0", done_b, pass_b, busy_b);
    end
    tests_run++;
    if (err_b !== 16'hFFFF || lerr_b !== 4'hF) begin
      tests_failed++;
      $display("FAIL sat_count: err/lane got %h/%h expected FFFF/F", err_b, lerr_b);
    end
`ifdef DDR3_INT_EX_CHK_FIRST_FAIL_EN
    tests_run++;
    if (ffb_b !== 16'd0 || ffd_b !== 32'h0) begin
      tests_failed++;
      $display("FAIL sat_first_fail: got %0d/%h expected 0/0", ffb_b, ffd_b);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_clean();
    test_error();
    test_gaps();
    test_mid_start();
    test_reset_mid_run();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
